// File: rtl/mix_columns_stage.sv
// mix_columns_stage
// AES-128 MixColumns round stage, placed directly after ShiftRows. Two-stage
// elastic pipeline (S1 registers bytes and their xtime values, S2 combines them
// into the MixColumns result) with valid/ready flow control. Final-round states
// (in_last=1) pass through unchanged.
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        synchronous, active-high reset
//   in_valid   upstream state valid
//   in_ready   stage can accept (transfer on in_valid && in_ready)
//   in_data    state after ShiftRows; column c = bits [32c +: 32], row r byte = [32c+8r +: 8]
//   in_last    final round: bypass MixColumns
//   in_round   round tag, carried through unchanged
//   out_valid  output state valid
//   out_ready  downstream accepts (transfer on out_valid && out_ready)
//   out_data   MixColumns result (or in_data if last), same byte layout
//   out_round  tag of the state on out_data
module mix_columns_stage #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:127]     in_data,
  input  logic             in_last,
  input  logic [TAG_W-1:0] in_round,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:127]     out_data,
  output logic [TAG_W-1:0] out_round
);

  logic             r_s1_valid;
  logic             r_s1_last;
  logic [0:127]     r_s1_a;
  logic [0:127]     r_s1_b;
  logic [TAG_W-1:0] r_s1_round;

  logic             r_s2_valid;
  logic [0:127]     r_s2_data;
  logic [TAG_W-1:0] r_s2_round;

  logic             w_s1_adv;
  logic             w_s2_adv;
  logic [0:127]     w_xt;
  logic [0:127]     w_mix;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // a/b are one column with row 0 in the top byte; b holds xtime of each a byte.
  function automatic logic [31:0] mix_col(input logic [31:0] a, input logic [31:0] b);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    b0 = b[31:24];
    b1 = b[23:16];
    b2 = b[15:8];
    b3 = b[7:0];
    return {b0 ^ (b1 ^ a1) ^ a2 ^ a3,
            a0 ^ b1 ^ (b2 ^ a2) ^ a3,
            a0 ^ a1 ^ b2 ^ (b3 ^ a3),
            (b0 ^ a0) ^ a1 ^ a2 ^ b3};
  endfunction

  // Flow control depends only on valids and out_ready, never on data.
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  always_comb begin
    w_xt = '0;
    for (int i = 0; i < 16; i++) begin
      w_xt[8*i +: 8] = xtime(in_data[8*i +: 8]);
    end
  end

  always_comb begin
    w_mix = '0;
    for (int c = 0; c < 4; c++) begin
      w_mix[32*c +: 32] = mix_col(r_s1_a[32*c +: 32], r_s1_b[32*c +: 32]);
    end
  end

  // Data registers only load on a real transfer so bubbles do not toggle them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_round <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_round <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_last  <= in_last;
          r_s1_a     <= in_data;
          r_s1_b     <= w_xt;
          r_s1_round <= in_round;
        end
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data  <= r_s1_last ? r_s1_a : w_mix;
          r_s2_round <= r_s1_round;
        end
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_round = r_s2_round;

endmodule

// File: tb/tb_mix_columns_stage.sv
module tb_mix_columns_stage;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [0:127]   in_data;
  logic           in_last;
  logic [3:0]     in_round;
  logic           out_valid;
  logic           out_ready;
  logic [0:127]   out_data;
  logic [3:0]     out_round;

  int total = 0;
  int bad   = 0;

  mix_columns_stage #(.TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_round  (in_round),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_round (out_round)
  );

  always #5 clk = ~clk;

  // Reference: GF(2^8) multiply and the MixColumns circulant matrix {2,3,1,1}.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [0:127] mix_ref(input logic [0:127] s, input logic last);
    logic [0:127] o;
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          acc = acc ^ gmul(coef[(k - r + 4) % 4], s[32*c + 8*k +: 8]);
        end
        o[32*c + 8*r +: 8] = acc;
      end
    end
    return last ? s : o;
  endfunction

  function automatic logic [0:127] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Push one state with out_ready high; report result and cycles to out_valid.
  task automatic run_one(input logic [0:127] d, input logic last, input logic [3:0] rnd,
                         output logic [0:127] got, output logic [3:0] got_rnd,
                         output int lat);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = last;
    in_round  = rnd;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    got     = out_data;
    got_rnd = out_round;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    in_round = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++;
    if (out_data !== 128'd0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    total++;
    if (out_round !== 4'd0) begin bad++; $display("FAIL reset_out_round got=%0d exp=0", out_round); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_fips_column();
    logic [0:127] d, got, exp;
    logic [3:0]   gr;
    int           lat;
    d   = {32'hdb135345, 96'd0};
    exp = {32'h8e4da1bc, 96'd0};
    run_one(d, 1'b0, 4'd3, got, gr, lat);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL column_latency got=%0d exp=2", lat); end
    total++;
    if (got !== exp) begin bad++; $display("FAIL fips_column got=%h exp=%h", got, exp); end
    total++;
    if (gr !== 4'd3) begin bad++; $display("FAIL fips_column_round got=%0d exp=3", gr); end
  endtask

  task automatic test_fips_state();
    logic [0:127] d, got, exp;
    logic [3:0]   gr;
    int           lat;
    d   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    exp = 128'h046681e5e0cb199a48f8d37a2806264c;
    run_one(d, 1'b0, 4'd1, got, gr, lat);
    total++;
    if (got !== exp) begin bad++; $display("FAIL fips_state got=%h exp=%h", got, exp); end
    total++;
    if (gr !== 4'd1) begin bad++; $display("FAIL fips_state_round got=%0d exp=1", gr); end
  endtask

  task automatic test_bypass();
    logic [0:127] d, got;
    logic [3:0]   gr;
    int           lat;
    d = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    run_one(d, 1'b1, 4'd10, got, gr, lat);
    total++;
    if (got !== d) begin bad++; $display("FAIL bypass_data got=%h exp=%h", got, d); end
    total++;
    if (gr !== 4'd10) begin bad++; $display("FAIL bypass_round got=%0d exp=10", gr); end
  endtask

  task automatic test_identity();
    logic [31:0]  cin  [3];
    logic [31:0]  cout [3];
    logic [0:127] got, exp;
    logic [3:0]   gr;
    int           lat;
    cin  = '{32'hf20a225c, 32'h01010101, 32'hc6c6c6c6};
    cout = '{32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6};
    for (int i = 0; i < 3; i++) begin
      exp = {cout[i], cout[i], cout[i], cout[i]};
      run_one({cin[i], cin[i], cin[i], cin[i]}, 1'b0, 4'(i), got, gr, lat);
      total++;
      if (got !== exp) begin bad++; $display("FAIL identity_%0d got=%h exp=%h", i, got, exp); end
    end
    // Random states against the matrix model.
    for (int i = 0; i < 4; i++) begin
      logic [0:127] d;
      d   = rand_state();
      exp = mix_ref(d, 1'b0);
      run_one(d, 1'b0, 4'(i), got, gr, lat);
      total++;
      if (got !== exp) begin bad++; $display("FAIL random_%0d got=%h exp=%h", i, got, exp); end
    end
  endtask

  task automatic test_back_to_back();
    logic [0:127] vin [8];
    logic [0:127] vexp [8];
    for (int i = 0; i < 8; i++) begin
      vin[i]  = rand_state();
      vexp[i] = mix_ref(vin[i], 1'b0);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (k < 8);
      in_data   = (k < 8) ? vin[k] : '0;
      in_last   = 1'b0;
      in_round  = 4'(k);
      #1;
      if (k < 8) begin
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready k=%0d got=%b exp=1", k, in_ready); end
      end
      if (k >= 2) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== vexp[k-2]) begin
          bad++;
          $display("FAIL b2b_out k=%0d valid=%b got=%h exp=%h", k, out_valid, out_data, vexp[k-2]);
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [0:127] vin [8];
    logic [0:127] vexp [8];
    logic [3:0]   rin [8];
    logic         lin [8];
    logic [0:127] held_data;
    logic         held;
    int           idx_in, idx_out, cnt, cyc;
    logic         exp_rdy;
    for (int i = 0; i < 8; i++) begin
      vin[i]  = rand_state();
      lin[i]  = ($urandom_range(0, 3) == 0);
      rin[i]  = 4'($urandom_range(0, 15));
      vexp[i] = mix_ref(vin[i], lin[i]);
    end
    idx_in = 0; idx_out = 0; cnt = 0; cyc = 0; held = 1'b0; held_data = '0;
    while (idx_out < 8 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (idx_in < 8);
      in_data   = (idx_in < 8) ? vin[idx_in] : '0;
      in_last   = (idx_in < 8) ? lin[idx_in] : 1'b0;
      in_round  = (idx_in < 8) ? rin[idx_in] : 4'd0;
      #1;
      exp_rdy = !(cnt == 2 && !out_ready);
      total++;
      if (in_ready !== exp_rdy) begin
        bad++;
        $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy);
      end
      if (held) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== held_data) begin
          bad++;
          $display("FAIL bp_stable cyc=%0d valid=%b got=%h exp=%h", cyc, out_valid, out_data,
                   held_data);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (cnt == 0 || out_data !== vexp[idx_out] || out_round !== rin[idx_out]) begin
          bad++;
          $display("FAIL bp_order idx=%0d got=%h/%0d exp=%h/%0d", idx_out, out_data, out_round,
                   vexp[idx_out], rin[idx_out]);
        end
        idx_out++;
        cnt--;
      end
      if (in_valid && in_ready) begin
        idx_in++;
        cnt++;
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
    end
    total++;
    if (idx_out != 8) begin bad++; $display("FAIL bp_timeout got=%0d exp=8 outputs", idx_out); end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    // Nothing may be emitted twice.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_extra k=%0d got=%b exp=0", k, out_valid); end
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_last   = 1'b0;
    in_data   = rand_state();
    in_round  = 4'd5;
    @(posedge clk);
    @(negedge clk);
    in_data  = rand_state();
    in_round = 4'd6;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_full got=%b/%b exp=1/0", out_valid, in_ready);
    end
    do_reset();
    total++;
    if (out_valid !== 1'b0 || out_data !== 128'd0) begin
      bad++;
      $display("FAIL mid_reset_out valid=%b data=%h exp=0/0", out_valid, out_data);
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_in_ready got=%b exp=1", in_ready); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_emit k=%0d got=%b exp=0", k, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_fips_column();
    test_fips_state();
    test_bypass();
    test_identity();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
